// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: 8N1 UART transmitter draining an upstream byte FIFO.
// Strobes one read per frame, captures the byte a cycle later, shifts LSB-first.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       enable_in,
    input  logic       fifo_readable_in,
    input  logic [7:0] fifo_rdata_in,
    output logic       fifo_read_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic       done_out
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic        tx_q, tx_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  bitidx_q, bitidx_d;
    logic        done_q, done_d;
    logic        bit_end;

    assign bit_end       = (count_q == LAST);
    assign fifo_read_out = !reset_in && (state_q == IDLE)
                           && enable_in && fifo_readable_in;
    assign tx_out        = tx_q;
    assign busy_out      = (state_q != IDLE);
    assign done_out      = done_q;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            shift_q  <= 8'h00;
            count_q  <= 16'h0000;
            bitidx_q <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            bitidx_q <= bitidx_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath update for each frame phase.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        shift_d  = shift_q;
        count_d  = count_q;
        bitidx_d = bitidx_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_read_out) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo_rdata_in;
                tx_d    = 1'b0;
                count_d = 16'h0000;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    count_d  = 16'h0000;
                    tx_d     = shift_q[0];
                    bitidx_d = 3'd0;
                    state_d  = DATA;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    count_d = 16'h0000;
                    if (bitidx_q != 3'd7) begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        tx_d     = shift_q[1];
                        bitidx_d = bitidx_q + 3'd1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    count_d = 16'h0000;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Byte-serial 8N1 UART transmitter that drains the 16-byte FIFO sitting directly upstream of it. When enabled and the FIFO reports data, it issues a single-cycle read strobe, captures the byte on the following cycle and shifts it out LSB-first with one start bit and one stop bit at a fixed clocks-per-bit rate. It is the consumer half of the transmit path; the FIFO absorbs bursty writes from the host side.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2..65535. The bit counter is 16 bits wide.
- `clock_in` input 1: positive edge-triggered system clock. This is the only clock.
- `reset_in` input 1: reset, asynchronous and active-high.
- `enable_in` input 1: when high, new frames may start. It is sampled only in IDLE.
- `fifo_readable_in` input 1: the FIFO is non-empty.
- `fifo_rdata_in` input 8: FIFO read data. It is valid on the cycle after `fifo_read_out` is high.
- `fifo_read_out` output 1: FIFO read strobe. It is high for exactly one cycle per frame.
- `tx_out` output 1: serial line. It idles high and is registered.
- `busy_out` output 1: high whenever the state is not IDLE.
- `done_out` output 1: registered one-cycle pulse at the end of the stop bit.

## Operation
- States are IDLE, FETCH, START, DATA and STOP. The state, `tx_out`, the 8-bit shift register, the 16-bit `count` and the 3-bit `bitidx` are all registered.
- `fifo_read_out` = (state == IDLE) && `enable_in` && `fifo_readable_in`. It is combinational.
- IDLE: `tx_out` stays at 1. If `fifo_read_out` is high, the next state is FETCH.
- FETCH, single cycle: on the edge, the shift register takes `fifo_rdata_in`, `tx_out` goes to 0, `count` goes to 0, and the state moves to START.
- In START, DATA and STOP, `count` increments every cycle. The bit ends when `count == CLKS_PER_BIT-1`, and `count` then returns to 0.
- End of START: `tx_out` takes shift[0], `bitidx` goes to 0, and the state moves to DATA.
- End of DATA with `bitidx < 7`: the shift register shifts right, `tx_out` takes the next bit, and `bitidx` increments.
- End of DATA with `bitidx == 7`: `tx_out` goes to 1 and the state moves to STOP.
- End of STOP: the state returns to IDLE and `done_out` is 1 for the next cycle.
- `enable_in` falling mid-frame has no effect. The current frame completes, and no new read is issued while `enable_in` is low.
- `fifo_readable_in` is ignored outside IDLE.
- The block never reads an empty FIFO. The strobe is gated by `fifo_readable_in` in the same cycle.
- Reset, including mid-frame, takes effect immediately:
  - state IDLE, `tx_out` 1;
  - `busy_out` 0, `done_out` 0, `fifo_read_out` 0;
  - `count` 0, `bitidx` 0, shift register 0.
- The partial frame is abandoned and the line returns high at once. A byte already strobed out of the FIFO is lost.

## Timing
- Let N = `CLKS_PER_BIT` and let T0 be the IDLE cycle with `fifo_read_out` high.
- T1 is FETCH: the data is captured. `busy_out` is high from T1.
- `tx_out` = 0 during cycles T2 .. T2+N-1.
- Data bit i (i = 0..7) is driven during T2+N(1+i) .. T2+N(2+i)-1.
- The stop bit is driven during T2+9N .. T2+10N-1.
- IDLE is re-entered at T2+10N, and `done_out` is high in that same cycle.
- The earliest next strobe is T2+10N. Back-to-back frames therefore have N+2 high cycles between data bit 7 and the next start bit (the stop bit plus the IDLE and FETCH cycles).
- Frame period is 10N+2 cycles.

## Test plan
- Reset: with N=4, assert `reset_in` and hold `fifo_readable_in`=1 → `tx_out`=1, `fifo_read_out`=0, `busy_out`=0. After release with `enable_in`=1, the strobe is seen in the first cycle.
- Single byte 0xA5, N=4 → the line shows 0 for 4 cycles, then the bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. `done_out` pulses at T2+40, and there is exactly one `fifo_read_out` pulse.
- Back-to-back 0x00 then 0xFF, with `fifo_readable_in` held high, N=4 → two strobes 42 cycles apart. The second start bit begins 6 cycles after the first frame's bit 7 ends.
- Enable gating: `enable_in`=0 with the FIFO non-empty → no strobe and the line stays high. Dropping `enable_in` at frame bit 3 → the frame completes and no further strobe occurs.
- Empty FIFO: `fifo_readable_in`=0 and `enable_in`=1 → `fifo_read_out` never asserts and `busy_out` stays 0.
- Mid-frame reset during data bit 5 → `tx_out`=1 asynchronously, before the next clock edge. No `done_out` pulse. The next frame starts cleanly with a full-length start bit.
